// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_STEP       = 32'd4;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory request and decoder handshake bundle of the fetch stage
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] ImmOp;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, fault,
    input  imem_ack, imem_rdata, instr_ready, PCSrc, ImmOp
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, fault,
    output imem_ack, imem_rdata, instr_ready, PCSrc, ImmOp
  );

endinterface

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - next PC: held PC plus either the branch offset or one instruction step
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic [31:0] imm_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] step;

  assign step      = pc_src_i ? imm_i : INSTR_STEP;
  assign pc_next_o = pc_i + step;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch FSM holding one word for the decoder
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  pc_next;

  pc_next_calc u_pc_next_calc (
    .pc_i      (instr_pc_q),
    .pc_src_i  (bus.PCSrc),
    .imm_i     (bus.ImmOp),
    .pc_next_o (pc_next)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = VALID;
        end
      end
      VALID: begin
        // Redirect operands only matter in the cycle the held word is consumed.
        if (bus.instr_ready) begin
          if (word_aligned(pc_next)) begin
            pc_d    = pc_next;
            state_d = FETCH;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
    end
  end

  // Handshake outputs are gated so they read low for the whole reset window.
  assign bus.imem_req    = rst_n && (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = rst_n && (state_q == VALID);
  assign bus.fault       = fault_q;

endmodule
